// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock FIFO with occupancy count, almost flags and overflow/underflow pulses
// Define SYNC_FIFO_FLAGS_FWFT_EN for first-word-fall-through reads (BRAM prefetch into an output register).
module sync_fifo_flags #(
  parameter int DATA_WIDTH         = 8,
  parameter int ADDR_WIDTH         = 3,
  parameter int ALMOST_FULL_LEVEL  = 6,
  parameter int ALMOST_EMPTY_LEVEL = 2
) (
  input  logic                  clock,
  input  logic                  asyncResetN,
  input  logic                  writeEnable,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic                  full,
  output logic                  almostFull,
  output logic                  overflow,
  input  logic                  readEnable,
  output logic [DATA_WIDTH-1:0] readData,
  output logic                  empty,
  output logic                  almostEmpty,
  output logic                  underflow,
  output logic [ADDR_WIDTH:0]   count
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   AF_C    = ALMOST_FULL_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   AE_C    = ALMOST_EMPTY_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   ONE_C   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   next_count;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  ram_rd;

  assign wr_acc = writeEnable && !full;
  assign rd_acc = readEnable && !empty;

  always_comb begin
    next_count = count;
    case ({wr_acc, rd_acc})
      2'b10:   next_count = count + ONE_C;
      2'b01:   next_count = count - ONE_C;
      default: next_count = count;
    endcase
  end

  // Storage has no reset so it maps onto block RAM.
  always_ff @(posedge clock) begin
    if (wr_acc) begin
      mem[wr_ptr] <= writeData;
    end
  end

  always_ff @(posedge clock or negedge asyncResetN) begin
    if (!asyncResetN) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      full        <= 1'b0;
      almostFull  <= 1'b0;
      almostEmpty <= 1'b1;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (ram_rd) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count       <= next_count;
      full        <= (next_count == DEPTH_C);
      almostFull  <= (next_count >= AF_C);
      almostEmpty <= (next_count <= AE_C);
      overflow    <= writeEnable && full;
      underflow   <= readEnable && empty;
    end
  end

`ifdef SYNC_FIFO_FLAGS_FWFT_EN
  // Two-stage prefetch: BRAM output register, then the visible output register.
  logic [ADDR_WIDTH:0]   ram_words;
  logic [ADDR_WIDTH:0]   next_ram_words;
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  ram_q_valid;
  logic                  ram_q_move;

  assign ram_q_move = ram_q_valid && (empty || rd_acc);
  assign ram_rd     = (ram_words != '0) && (!ram_q_valid || ram_q_move);

  always_comb begin
    next_ram_words = ram_words;
    case ({wr_acc, ram_rd})
      2'b10:   next_ram_words = ram_words + ONE_C;
      2'b01:   next_ram_words = ram_words - ONE_C;
      default: next_ram_words = ram_words;
    endcase
  end

  always_ff @(posedge clock or negedge asyncResetN) begin
    if (!asyncResetN) begin
      ram_words   <= '0;
      ram_q       <= '0;
      ram_q_valid <= 1'b0;
      readData    <= '0;
      empty       <= 1'b1;
    end else begin
      ram_words <= next_ram_words;
      if (ram_rd) begin
        ram_q       <= mem[rd_ptr];
        ram_q_valid <= 1'b1;
      end else if (ram_q_move) begin
        ram_q_valid <= 1'b0;
      end
      if (ram_q_move) begin
        readData <= ram_q;
        empty    <= 1'b0;
      end else if (rd_acc) begin
        empty <= 1'b1;
      end
    end
  end
`else
  assign ram_rd = rd_acc;

  always_ff @(posedge clock or negedge asyncResetN) begin
    if (!asyncResetN) begin
      readData <= '0;
      empty    <= 1'b1;
    end else begin
      if (rd_acc) begin
        readData <= mem[rd_ptr];
      end
      empty <= (next_count == '0);
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - table-driven directed bench for sync_fifo_flags (DEPTH=8, AF=6, AE=2)
// Follows SYNC_FIFO_FLAGS_FWFT_EN to select the matching vector table.
module tb_sync_fifo_flags;
  logic       clock = 1'b0;
  logic       asyncResetN;
  logic       writeEnable;
  logic [7:0] writeData;
  logic       full;
  logic       almostFull;
  logic       overflow;
  logic       readEnable;
  logic [7:0] readData;
  logic       empty;
  logic       almostEmpty;
  logic       underflow;
  logic [3:0] count;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic       we;
    logic [7:0] wd;
    logic       re;
    logic [3:0] cnt;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       ovf;
    logic       udf;
    logic [7:0] rd;
  } vec_t;

  vec_t vecs[$];

  sync_fifo_flags #(
    .DATA_WIDTH(8), .ADDR_WIDTH(3), .ALMOST_FULL_LEVEL(6), .ALMOST_EMPTY_LEVEL(2)
  ) dut (
    .clock(clock), .asyncResetN(asyncResetN),
    .writeEnable(writeEnable), .writeData(writeData),
    .full(full), .almostFull(almostFull), .overflow(overflow),
    .readEnable(readEnable), .readData(readData),
    .empty(empty), .almostEmpty(almostEmpty), .underflow(underflow),
    .count(count)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(int we, int wd, int re, int cnt, int emp, int ovf, int udf, int rd);
    vec_t v;
    v.we    = we[0];
    v.wd    = wd[7:0];
    v.re    = re[0];
    v.cnt   = cnt[3:0];
    v.full  = (cnt == 8);
    v.empty = emp[0];
    v.af    = (cnt >= 6);
    v.ae    = (cnt <= 2);
    v.ovf   = ovf[0];
    v.udf   = udf[0];
    v.rd    = rd[7:0];
    return v;
  endfunction

  task automatic chk(input string tag, input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s %s: got 0x%0h, expected 0x%0h", tag, nm, act, exp);
    end
  endtask

  task automatic compare(input vec_t v, input string tag);
    vectors++;
    chk(tag, "count", 32'(count), 32'(v.cnt));
    chk(tag, "full", 32'(full), 32'(v.full));
    chk(tag, "empty", 32'(empty), 32'(v.empty));
    chk(tag, "almostFull", 32'(almostFull), 32'(v.af));
    chk(tag, "almostEmpty", 32'(almostEmpty), 32'(v.ae));
    chk(tag, "overflow", 32'(overflow), 32'(v.ovf));
    chk(tag, "underflow", 32'(underflow), 32'(v.udf));
    chk(tag, "readData", 32'(readData), 32'(v.rd));
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clock);
    writeEnable = v.we;
    writeData   = v.wd;
    readEnable  = v.re;
    @(posedge clock);
    #1;
    compare(v, tag);
    writeEnable = 1'b0;
    readEnable  = 1'b0;
  endtask

  initial begin
    asyncResetN = 1'b0;
    writeEnable = 1'b0;
    writeData   = 8'h00;
    readEnable  = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    asyncResetN = 1'b1;
    apply(mk(0, 0, 0, 0, 1, 0, 0, 0), "reset");

`ifdef SYNC_FIFO_FLAGS_FWFT_EN
    vecs.push_back(mk(1, 8'hA5, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 8'hA5));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 8'hA5));
    vecs.push_back(mk(1, 8'hB0, 0, 1, 1, 0, 0, 8'hA5));
    vecs.push_back(mk(1, 8'hB1, 0, 2, 1, 0, 0, 8'hA5));
    vecs.push_back(mk(1, 8'hB2, 0, 3, 0, 0, 0, 8'hB0));
    vecs.push_back(mk(1, 8'hB3, 0, 4, 0, 0, 0, 8'hB0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 0, 4, 0, 0, 0, 8'hB0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 0, 1, 3 - i, i == 3, 0, 0, (i == 3) ? 8'hB3 : 8'hB1 + i));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 1, 8'hB3));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 8'hB3));
`else
    // fill, overflow, drain, underflow
    for (int i = 0; i < 8; i++) vecs.push_back(mk(1, 8'h10 + i, 0, i + 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h18, 0, 8, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++) vecs.push_back(mk(0, 0, 1, 7 - i, i == 7, 0, 0, 8'h10 + i));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 1, 8'h17));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 8'h17));
    // pointer wrap-around
    for (int i = 0; i < 5; i++) vecs.push_back(mk(1, 8'h20 + i, 0, i + 1, 0, 0, 0, 8'h17));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 1, 4 - i, i == 4, 0, 0, 8'h20 + i));
    for (int i = 0; i < 6; i++) vecs.push_back(mk(1, 8'h30 + i, 0, i + 1, 0, 0, 0, 8'h24));
    for (int i = 0; i < 6; i++) vecs.push_back(mk(0, 0, 1, 5 - i, i == 5, 0, 0, 8'h30 + i));
    // simultaneous read+write at count=3, then at full
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 8'h40 + i, 0, i + 1, 0, 0, 0, 8'h35));
    for (int i = 0; i < 20; i++)
      vecs.push_back(mk(1, 8'h50 + i, 1, 3, 0, 0, 0, (i < 3) ? 8'h40 + i : 8'h50 + i - 3));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(1, 8'h70 + i, 0, 4 + i, 0, 0, 0, 8'h60));
    vecs.push_back(mk(1, 8'h99, 1, 7, 0, 1, 0, 8'h61));
    vecs.push_back(mk(0, 0, 1, 6, 0, 0, 0, 8'h62));
    vecs.push_back(mk(0, 0, 1, 5, 0, 0, 0, 8'h63));
`endif

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("v%0d", i));

    // reset between edges must clear everything without waiting for a clock
    @(negedge clock);
    #2;
    asyncResetN = 1'b0;
    #1;
    compare(mk(0, 0, 0, 0, 1, 0, 0, 0), "async_reset");
    @(negedge clock);
    asyncResetN = 1'b1;
    apply(mk(0, 0, 1, 0, 1, 0, 1, 0), "post_reset_read");
`ifndef SYNC_FIFO_FLAGS_FWFT_EN
    apply(mk(1, 8'hAB, 0, 1, 0, 0, 0, 0), "post_reset_write");
    apply(mk(0, 0, 1, 0, 1, 0, 0, 8'hAB), "post_reset_pop");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
